latency_probe_gen: RTL and testbench

- Transmit-side companion to the latency-measurement shift-register stage. It generates bursts of timestamped AXI-stream probe packets in s_axis/tuser format: a CHDR header in tuser[127:64] and the VITA time in tuser[63:0].
- It sits between axi_wrapper's s_axis_data port (or a loopback bench) and the receiving stage, which later subtracts tuser[47:0] from its own time.
- A host-triggered start launches a burst of N packets of L words, separated by a programmable idle gap.

---
 rtl/latency_probe_gen.sv | 196 +++++++++++++++++++
 tb/tb_latency_probe_gen.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latency_probe_gen.sv
// rtl/latency_probe_gen.sv - burst generator of timestamped AXI-stream latency probe packets
// Optional stall statistics (stall_cycles, max_stall) are built when LATENCY_PROBE_STALL_STATS_EN is defined.
module latency_probe_gen #(
  parameter int         MAX_LEN_W   = 16,
  parameter logic [7:0] DEFAULT_GAP = 8'd16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear_tx_seqnum,
  input  logic [MAX_LEN_W-1:0] num_pkts,
  input  logic [MAX_LEN_W-1:0] pkt_len,
  input  logic [7:0]           gap_cycles,
  input  logic [63:0]          timer,
  input  logic [15:0]          src_sid,
  input  logic [15:0]          next_dst_sid,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [127:0]         m_axis_tuser,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          pkts_sent
`ifdef LATENCY_PROBE_STALL_STATS_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [15:0]          max_stall
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  localparam logic [MAX_LEN_W-1:0] ONE = MAX_LEN_W'(1);
  localparam logic [MAX_LEN_W-1:0] TWO = MAX_LEN_W'(2);

  state_t               state;
  logic [MAX_LEN_W-1:0] len_r;
  logic [MAX_LEN_W-1:0] npkts_r;
  logic [MAX_LEN_W-1:0] word_cnt;
  logic [MAX_LEN_W-1:0] sent_cnt;
  logic [7:0]           gap_r;
  logic [7:0]           gap_cnt;
  logic [11:0]          seqnum;
  logic [63:0]          ts;
  logic [63:0]          hdr;

  logic                 fire;
  logic                 last_pkt;
  logic [7:0]           eff_gap_in;
  logic [MAX_LEN_W-1:0] len_in;
  logic [11:0]          seq_in;
  logic [15:0]          pkts_sent_inc;

  function automatic logic [63:0] make_hdr(input logic [11:0] seq,
                                           input logic [MAX_LEN_W-1:0] len,
                                           input logic eob,
                                           input logic [15:0] src,
                                           input logic [15:0] dst);
    logic [15:0] bytes;
    bytes = 16'(len) << 2;
    return {2'b00, 1'b1, eob, seq, bytes, src, dst};
  endfunction

  assign fire          = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid && (word_cnt == len_r - ONE);
  assign m_axis_tdata  = {seqnum, 4'h0, word_cnt[15:0]};
  assign m_axis_tuser  = {hdr, ts};
  assign busy          = (state != S_IDLE);
  // sent_cnt counts completed packets, so this flags the packet now in flight as the last one
  assign last_pkt      = (sent_cnt + ONE == npkts_r);
  assign eff_gap_in    = (gap_cycles == 8'hFF) ? DEFAULT_GAP : gap_cycles;
  assign len_in        = (pkt_len == '0) ? ONE : pkt_len;
  assign seq_in        = clear_tx_seqnum ? 12'h000 : seqnum;
  assign pkts_sent_inc = (pkts_sent == 16'hFFFF) ? pkts_sent : pkts_sent + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      len_r         <= '0;
      npkts_r       <= '0;
      word_cnt      <= '0;
      sent_cnt      <= '0;
      gap_r         <= 8'd0;
      gap_cnt       <= 8'd0;
      seqnum        <= 12'h000;
      ts            <= 64'd0;
      hdr           <= 64'd0;
      m_axis_tvalid <= 1'b0;
      done          <= 1'b0;
      pkts_sent     <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear_tx_seqnum) begin
            seqnum <= 12'h000;
          end
          if (start) begin
            len_r     <= len_in;
            npkts_r   <= num_pkts;
            gap_r     <= eff_gap_in;
            word_cnt  <= '0;
            sent_cnt  <= '0;
            pkts_sent <= 16'd0;
            if (num_pkts == '0) begin
              done <= 1'b1;
            end else begin
              ts            <= timer;
              hdr           <= make_hdr(seq_in, len_in, (num_pkts == ONE) || stop,
                                        src_sid, next_dst_sid);
              m_axis_tvalid <= 1'b1;
              state         <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (fire) begin
            if (m_axis_tlast) begin
              word_cnt  <= '0;
              seqnum    <= seqnum + 12'd1;
              sent_cnt  <= sent_cnt + ONE;
              pkts_sent <= pkts_sent_inc;
              if (last_pkt || stop) begin
                m_axis_tvalid <= 1'b0;
                done          <= 1'b1;
                state         <= S_IDLE;
              end else if (gap_r == 8'd0) begin
                // back-to-back: next packet's header and timestamp launch on this edge
                ts  <= timer;
                hdr <= make_hdr(seqnum + 12'd1, len_r, (sent_cnt + TWO == npkts_r),
                                src_sid, next_dst_sid);
              end else begin
                gap_cnt       <= gap_r - 8'd1;
                m_axis_tvalid <= 1'b0;
                state         <= S_GAP;
              end
            end else begin
              word_cnt <= word_cnt + ONE;
            end
          end
        end
        S_GAP: begin
          if (stop) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (gap_cnt == 8'd0) begin
            ts            <= timer;
            hdr           <= make_hdr(seqnum, len_r, last_pkt, src_sid, next_dst_sid);
            m_axis_tvalid <= 1'b1;
            state         <= S_SEND;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          m_axis_tvalid <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LATENCY_PROBE_STALL_STATS_EN
  logic        stalled;
  logic [15:0] run_len;
  logic [15:0] run_next;

  assign stalled  = m_axis_tvalid && !m_axis_tready;
  assign run_next = (run_len == 16'hFFFF) ? run_len : run_len + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 32'd0;
      max_stall    <= 16'd0;
      run_len      <= 16'd0;
    end else if (state == S_IDLE && start) begin
      stall_cycles <= 32'd0;
      max_stall    <= 16'd0;
      run_len      <= 16'd0;
    end else if (stalled) begin
      if (stall_cycles != 32'hFFFF_FFFF) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      run_len <= run_next;
      if (run_next > max_stall) begin
        max_stall <= run_next;
      end
    end else begin
      run_len <= 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_latency_probe_gen.sv
// tb/tb_latency_probe_gen.sv - directed self-checking bench for latency_probe_gen
module tb_latency_probe_gen;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clear_tx_seqnum = 1'b0;
  logic [15:0]  num_pkts = 16'd0;
  logic [15:0]  pkt_len = 16'd0;
  logic [7:0]   gap_cycles = 8'd0;
  logic [63:0]  timer = 64'h1000;
  logic [15:0]  src_sid = 16'hA5C3;
  logic [15:0]  next_dst_sid = 16'h1234;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic [127:0] m_axis_tuser;
  logic         busy;
  logic         done;
  logic [15:0]  pkts_sent;
`ifdef LATENCY_PROBE_STALL_STATS_EN
  logic [31:0]  stall_cycles;
  logic [15:0]  max_stall;
`endif

  latency_probe_gen dut (
`ifdef LATENCY_PROBE_STALL_STATS_EN
    .stall_cycles    (stall_cycles),
    .max_stall       (max_stall),
`endif
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .clear_tx_seqnum (clear_tx_seqnum),
    .num_pkts        (num_pkts),
    .pkt_len         (pkt_len),
    .gap_cycles      (gap_cycles),
    .timer           (timer),
    .src_sid         (src_sid),
    .next_dst_sid    (next_dst_sid),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tuser    (m_axis_tuser),
    .busy            (busy),
    .done            (done),
    .pkts_sent       (pkts_sent)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 timer = timer + 64'd1;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_hdr(input logic [11:0] seq, input logic [15:0] len,
                                          input logic eob);
    logic [15:0] bytes;
    bytes = len * 16'd4;
    return {2'b00, 1'b1, eob, seq, bytes, 16'hA5C3, 16'h1234};
  endfunction

  logic [31:0]  w_data[$];
  logic         w_last[$];
  logic [127:0] p_user[$];
  logic [63:0]  p_first_t[$];
  logic [63:0]  p_end_t[$];
  int           done_cnt = 0;
  int           stall_seen = 0;
  bit           in_pkt = 1'b0;
  bit           prev_stall = 1'b0;
  logic [31:0]  h_data;
  logic [127:0] h_user;
  logic         h_last;

  // passive monitor: packet boundaries, handshaken words, stall stability
  always @(negedge clk) begin
    if (!reset) begin
      in_pkt     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (m_axis_tvalid) begin
        if (prev_stall) begin
          check("hold_tdata", 128'(m_axis_tdata), 128'(h_data));
          check("hold_tuser", m_axis_tuser, h_user);
          check("hold_tlast", 128'(m_axis_tlast), 128'(h_last));
        end
        if (!in_pkt) begin
          in_pkt = 1'b1;
          p_user.push_back(m_axis_tuser);
          p_first_t.push_back(timer);
        end
        if (m_axis_tready) begin
          w_data.push_back(m_axis_tdata);
          w_last.push_back(m_axis_tlast);
          if (m_axis_tlast) begin
            in_pkt = 1'b0;
            p_end_t.push_back(timer);
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          stall_seen++;
          h_data = m_axis_tdata;
          h_user = m_axis_tuser;
          h_last = m_axis_tlast;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs;
    w_data.delete();
    w_last.delete();
    p_user.delete();
    p_first_t.delete();
    p_end_t.delete();
    done_cnt   = 0;
    stall_seen = 0;
  endtask

  // returns at the negedge of the cycle after start is sampled
  task automatic launch(input logic [15:0] np, input logic [15:0] pl, input logic [7:0] gp,
                        input bit clr, output logic [63:0] t_first);
    tick;
    num_pkts        = np;
    pkt_len         = pl;
    gap_cycles      = gp;
    clear_tx_seqnum = clr;
    start           = 1'b1;
    tick;
    start           = 1'b0;
    clear_tx_seqnum = 1'b0;
    @(negedge clk);
    t_first = timer;
  endtask

  task automatic run_to_done(input int budget, input bit toggle);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (toggle) m_axis_tready = ~m_axis_tready;
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", 128'(ok), 128'(1));
    tick;
    @(negedge clk);
    check("done_pulse_low", 128'(done), 128'(0));
  endtask

  task automatic wait_words(input int n, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (w_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check("words_reached", 128'(ok), 128'(1));
  endtask

  logic [63:0] t0;
  logic [11:0] s;
  logic [15:0] w;

  initial begin
    // reset state
    tick; tick; tick;
    @(negedge clk);
    check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst_tuser", m_axis_tuser, 128'(0));
    check("rst_tdata", 128'(m_axis_tdata), 128'(0));
    check("rst_tlast", 128'(m_axis_tlast), 128'(0));
    check("rst_flags", 128'({busy, done}), 128'(0));
    check("rst_pkts_sent", 128'(pkts_sent), 128'(0));
    tick;
    reset = 1'b1;

    // 3 packets x 4 words, gap 2
    clear_logs();
    launch(16'd3, 16'd4, 8'd2, 1'b0, t0);
    check("t1_busy", 128'(busy), 128'(1));
    run_to_done(200, 1'b0);
    check("t1_nwords", 128'(w_data.size()), 128'(12));
    check("t1_npkts", 128'(p_user.size()), 128'(3));
    check("t1_latency", 128'(p_first_t[0]), 128'(t0));
    for (int i = 0; i < 12; i++) begin
      s = 12'(i / 4);
      w = 16'(i % 4);
      check("t1_tdata", 128'(w_data[i]), 128'({s, 4'h0, w}));
      check("t1_tlast", 128'(w_last[i]), 128'((i % 4) == 3));
    end
    for (int p = 0; p < 3; p++) begin
      check("t1_hdr", 128'(p_user[p][127:64]), 128'(exp_hdr(12'(p), 16'd4, p == 2)));
      check("t1_ts", 128'(p_user[p][63:0]), 128'(p_first_t[p] - 64'd1));
    end
    for (int p = 0; p < 2; p++)
      check("t1_gap", 128'(p_first_t[p+1] - p_end_t[p] - 64'd1), 128'(2));
    check("t1_done_cnt", 128'(done_cnt), 128'(1));
    check("t1_pkts_sent", 128'(pkts_sent), 128'(3));
    check("t1_busy_end", 128'(busy), 128'(0));

    // 2 packets x 5 words, tready toggling, default gap
    clear_logs();
    launch(16'd2, 16'd5, 8'hFF, 1'b0, t0);
    run_to_done(300, 1'b1);
    m_axis_tready = 1'b1;
    check("t2_nwords", 128'(w_data.size()), 128'(10));
    for (int i = 0; i < 10; i++) begin
      s = 12'(3 + i / 5);
      w = 16'(i % 5);
      check("t2_tdata", 128'(w_data[i]), 128'({s, 4'h0, w}));
    end
    check("t2_hdr0", 128'(p_user[0][127:64]), 128'(exp_hdr(12'd3, 16'd5, 1'b0)));
    check("t2_hdr1", 128'(p_user[1][127:64]), 128'(exp_hdr(12'd4, 16'd5, 1'b1)));
    check("t2_default_gap", 128'(p_first_t[1] - p_end_t[0] - 64'd1), 128'(16));
    check("t2_stalls_seen", 128'(stall_seen > 0), 128'(1));
`ifdef LATENCY_PROBE_STALL_STATS_EN
    check("t2_stall_cycles", 128'(stall_cycles), 128'(stall_seen));
    check("t2_max_stall", 128'(max_stall), 128'(1));
`endif

    // 4096 single-word back-to-back packets, clear coincident with start
    clear_logs();
    launch(16'd4096, 16'd1, 8'd0, 1'b1, t0);
    run_to_done(5000, 1'b0);
    check("t3_nwords", 128'(w_data.size()), 128'(4096));
    check("t3_first_seq", 128'(w_data[0][31:20]), 128'(0));
    check("t3_last_seq", 128'(w_data[4095][31:20]), 128'(12'hFFF));
    check("t3_last_tlast", 128'(w_last[4095]), 128'(1));
    check("t3_no_bubble", 128'(p_end_t[4095] - p_first_t[0]), 128'(4095));
    check("t3_last_hdr", 128'(p_user[4095][127:64]), 128'(exp_hdr(12'hFFF, 16'd1, 1'b1)));
    check("t3_b2b_ts", 128'(p_user[1][63:0]), 128'(p_first_t[1] - 64'd1));
    check("t3_pkts_sent", 128'(pkts_sent), 128'(4096));

    // pkt_len 0 behaves as 1 word; seqnum wrapped to 0
    clear_logs();
    launch(16'd1, 16'd0, 8'd0, 1'b0, t0);
    run_to_done(50, 1'b0);
    check("t3_len0_nwords", 128'(w_data.size()), 128'(1));
    check("t3_len0_hdr", 128'(p_user[0][127:64]), 128'(exp_hdr(12'h000, 16'd1, 1'b1)));
    check("t3_len0_tlast", 128'(w_last[0]), 128'(1));

    // standalone seqnum clear in IDLE
    tick;
    clear_tx_seqnum = 1'b1;
    tick;
    clear_tx_seqnum = 1'b0;
    clear_logs();
    launch(16'd1, 16'd2, 8'd0, 1'b0, t0);
    run_to_done(50, 1'b0);
    check("t3_clr_hdr", 128'(p_user[0][127:64]), 128'(exp_hdr(12'h000, 16'd2, 1'b1)));
    check("t3_clr_word1", 128'(w_data[1]), 128'({12'h000, 4'h0, 16'd1}));

    // stop raised mid packet 2 of 10
    clear_logs();
    launch(16'd10, 16'd8, 8'd2, 1'b0, t0);
    wait_words(11, 200);
    tick;
    stop = 1'b1;
    run_to_done(100, 1'b0);
    stop = 1'b0;
    check("t4_nwords", 128'(w_data.size()), 128'(16));
    check("t4_tlast", 128'(w_last[15]), 128'(1));
    check("t4_npkts", 128'(p_user.size()), 128'(2));
    check("t4_pkt2_hdr", 128'(p_user[1][127:64]), 128'(exp_hdr(12'd2, 16'd8, 1'b0)));
    check("t4_pkts_sent", 128'(pkts_sent), 128'(2));
    check("t4_done_cnt", 128'(done_cnt), 128'(1));
    check("t4_busy", 128'(busy), 128'(0));

    // num_pkts 0
    clear_logs();
    launch(16'd0, 16'd4, 8'd0, 1'b0, t0);
    check("t5_done", 128'(done), 128'(1));
    check("t5_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("t5_busy", 128'(busy), 128'(0));
    @(negedge clk);
    check("t5_done_low", 128'(done), 128'(0));
    check("t5_pkts_sent", 128'(pkts_sent), 128'(0));
    check("t5_nwords", 128'(w_data.size()), 128'(0));

    // reset mid-packet then a clean packet
    clear_logs();
    launch(16'd1, 16'd6, 8'd0, 1'b0, t0);
    wait_words(2, 50);
    tick;
    reset = 1'b0;
    #1;
    check("t6_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("t6_busy", 128'(busy), 128'(0));
    check("t6_seq", 128'(m_axis_tdata[31:20]), 128'(0));
    tick;
    reset = 1'b1;
    clear_logs();
    launch(16'd1, 16'd3, 8'd0, 1'b0, t0);
    run_to_done(50, 1'b0);
    check("t6_nwords", 128'(w_data.size()), 128'(3));
    check("t6_word0", 128'(w_data[0]), 128'(0));
    check("t6_word2", 128'(w_data[2]), 128'({12'h000, 4'h0, 16'd2}));
    check("t6_tlast", 128'(w_last[2]), 128'(1));
    check("t6_hdr", 128'(p_user[0][127:64]), 128'(exp_hdr(12'h000, 16'd3, 1'b1)));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
